// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier: one shift-add step per cycle,
// truncating normalisation, special operands resolved in the accept cycle.
module fp_mul_seq #(
    parameter int D_WIDTH = 32,
    parameter int M_WIDTH = 23,
    parameter int E_WIDTH = 8,
    parameter int BIAS    = 127
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] floating1_in,
    input  logic [D_WIDTH-1:0] floating2_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] floating_multiplication_out
);
    localparam int MW   = M_WIDTH + 1;
    localparam int PW   = 2 * MW;
    localparam int XW   = E_WIDTH + 2;
    localparam int CW   = $clog2(MW);
    localparam int EMAX = (1 << E_WIDTH) - 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MW - 1);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [PW-1:0]      acc;
    logic [MW-1:0]      mcand;
    logic [XW-1:0]      exp_q;
    logic               sign_q;

    logic [E_WIDTH-1:0] exp_a, exp_b;
    logic [M_WIDTH-1:0] frac_a, frac_b;
    logic               sign_in, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic               accept, special;
    logic [D_WIDTH-1:0] special_res, norm_res;
    logic [XW-1:0]      exp_sum, exp_n;
    logic [M_WIDTH-1:0] mant;
    logic [MW:0]        step_sum;

    assign exp_a   = floating1_in[D_WIDTH-2 -: E_WIDTH];
    assign exp_b   = floating2_in[D_WIDTH-2 -: E_WIDTH];
    assign frac_a  = floating1_in[M_WIDTH-1:0];
    assign frac_b  = floating2_in[M_WIDTH-1:0];
    assign sign_in = floating1_in[D_WIDTH-1] ^ floating2_in[D_WIDTH-1];
    assign a_nan   = (exp_a == E_WIDTH'(EMAX)) && (frac_a != '0);
    assign b_nan   = (exp_b == E_WIDTH'(EMAX)) && (frac_b != '0);
    assign a_inf   = (exp_a == E_WIDTH'(EMAX)) && (frac_a == '0);
    assign b_inf   = (exp_b == E_WIDTH'(EMAX)) && (frac_b == '0);
    assign a_zero  = (exp_a == '0);
    assign b_zero  = (exp_b == '0);
    assign exp_sum = XW'(exp_a) + XW'(exp_b) - XW'(BIAS);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // Denormals count as zero, so inf * denormal is also the invalid-operation NaN.
    always_comb begin
        special     = 1'b1;
        special_res = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            special_res = {1'b0, {(E_WIDTH + 1){1'b1}}, {(M_WIDTH - 1){1'b0}}};
        else if (a_inf || b_inf)
            special_res = {sign_in, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
        else if (a_zero || b_zero)
            special_res = {sign_in, {(D_WIDTH - 1){1'b0}}};
        else
            special = 1'b0;
    end

    always_comb begin
        exp_n    = exp_q + XW'(acc[PW-1]);
        mant     = acc[PW-1] ? acc[PW-2 -: M_WIDTH] : acc[PW-3 -: M_WIDTH];
        norm_res = {sign_q, exp_n[E_WIDTH-1:0], mant};
        if (!exp_n[XW-1] && (exp_n[XW-2:0] >= (XW - 1)'(EMAX)))
            norm_res = {sign_q, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
        else if (exp_n[XW-1] || (exp_n == '0))
            norm_res = {sign_q, {(D_WIDTH - 1){1'b0}}};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = special ? DONE : MUL;
            MUL:  if (cnt == CNT_LAST) state_next = NORM;
            NORM: state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Upper half of the accumulator adds the multiplicand; the lower half starts
    // as the multiplier and is consumed LSB first as the product shifts right.
    assign step_sum = {1'b0, acc[PW-1:MW]} + {1'b0, mcand};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                       <= IDLE;
            cnt                         <= '0;
            acc                         <= '0;
            mcand                       <= '0;
            exp_q                       <= '0;
            sign_q                      <= 1'b0;
            floating_multiplication_out <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                sign_q <= sign_in;
                exp_q  <= exp_sum;
                mcand  <= {1'b1, frac_b};
                acc    <= {{MW{1'b0}}, 1'b1, frac_a};
                cnt    <= '0;
                if (special)
                    floating_multiplication_out <= special_res;
            end else if (state == MUL) begin
                acc <= acc[0] ? {step_sum, acc[MW-1:1]} : {1'b0, acc[PW-1:1]};
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end else if (state == NORM) begin
                floating_multiplication_out <= norm_res;
            end
        end
    end
endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq: arithmetic reference model, per-cycle handshake
// and hold checks, latency, backpressure and mid-operation reset.
module tb_fp_mul_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid;
    logic [31:0] prod;

    int          checks = 0;
    int          failures = 0;
    bit          busy = 1'b0;
    logic [31:0] exp_res = '0;

    fp_mul_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .floating1_in(a), .floating2_in(b), .out_valid(out_valid),
        .out_ready(out_ready), .floating_multiplication_out(prod)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, want);
        end
    endtask

    // Reference: real-number rules on integer mantissas, truncation, flush-to-zero.
    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
        int              ex, ey, e;
        logic            s;
        bit              xn, yn, xi, yi, xz, yz;
        longint unsigned mx, my, p;
        logic [22:0]     m;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        xz = (ex == 0);
        yz = (ey == 0);
        if (xn || yn || (xi && yz) || (yi && xz)) return 32'h7FC00000;
        if (xi || yi) return {s, 8'hFF, 23'd0};
        if (xz || yz) return {s, 31'd0};
        mx = 64'(x[22:0]) + 64'd8388608;
        my = 64'(y[22:0]) + 64'd8388608;
        p  = mx * my;
        e  = ex + ey - 127;
        if (p >= 64'h8000_0000_0000) begin
            e = e + 1;
            m = 23'(p >> 24);
        end else begin
            m = 23'(p >> 23);
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), m};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_vs_busy", 32'(in_ready), 32'(!busy));
            if (busy && out_valid) chk("result_vs_model", prod, exp_res);
        end
    end

    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] want,
                         input int want_lat, input int hold, input string name);
        int n;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            chk({name, "_ready_timeout"}, 32'd0, 32'd1);
            return;
        end
        a = x; b = y; in_valid = 1'b1; exp_res = model(x, y);
        @(posedge clk);
        #1 in_valid = 1'b0; busy = 1'b1;
        n = 0; ok = 1'b0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (out_valid) begin ok = 1'b1; break; end
        end
        chk({name, "_latency"}, 32'(n), 32'(want_lat));
        chk({name, "_result"}, prod, want);
        for (int i = 0; i < hold; i++) begin
            if (i % 2 == 0) begin
                in_valid = 1'b1; a = 32'h3F800000; b = 32'h40400000;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk({name, "_bp_valid"}, 32'(out_valid), 32'd1);
            chk({name, "_bp_value"}, prod, want);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1 busy = 1'b0; out_ready = 1'b0;
        chk({name, "_ready_after"}, 32'(in_ready), 32'd1);
        chk({name, "_valid_after"}, 32'(out_valid), 32'd0);
        chk({name, "_out_kept"}, prod, want);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out", prod, 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

        chk("model_3x2", model(32'h40400000, 32'h40000000), 32'h40C00000);
        chk("model_1p5sq", model(32'h3FC00000, 32'h3FC00000), 32'h40100000);
        chk("model_infx0", model(32'h7F800000, 32'h00000000), 32'h7FC00000);

        do_op(32'h40400000, 32'h40000000, 32'h40C00000, 26, 0, "mul_3x2");
        do_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, 26, 0, "mul_1p5sq");
        do_op(32'hC0000000, 32'h40400000, 32'hC0C00000, 26, 0, "mul_neg");
        do_op(32'h00000000, 32'h40400000, 32'h00000000, 1, 0, "zero");
        do_op(32'h7F000000, 32'h7F000000, 32'h7F800000, 26, 0, "overflow");
        do_op(32'h7F800000, 32'h00000000, 32'h7FC00000, 1, 0, "inf_x_zero");
        do_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1, 0, "nan_in");
        do_op(32'hFF800000, 32'h40000000, 32'hFF800000, 1, 0, "neg_inf");
        do_op(32'h00800000, 32'h00800000, 32'h00000000, 26, 0, "underflow");
        do_op(32'h3FC00000, 32'h40400000, 32'h40900000, 26, 10, "backpressure");

        begin : reset_mid_mul
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (in_ready) begin ok = 1'b1; break; end
            end
            if (!ok) chk("rst_mid_ready_timeout", 32'd0, 32'd1);
            a = 32'h40400000; b = 32'h40000000; in_valid = 1'b1;
            exp_res = model(a, b);
            @(posedge clk);
            #1 in_valid = 1'b0; busy = 1'b1;
            repeat (12) @(negedge clk);
            #2 rst_n = 1'b0; busy = 1'b0;
            #1;
            chk("rst_mid_out", prod, 32'd0);
            chk("rst_mid_valid", 32'(out_valid), 32'd0);
            repeat (2) @(posedge clk);
            @(negedge clk);
            #2 rst_n = 1'b1;
            #1 chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        end

        do_op(32'h40400000, 32'h40000000, 32'h40C00000, 26, 0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp_mul_seq.md
FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 Parameters SHALL be: D_WIDTH, 32, word width; M_WIDTH, 23, stored mantissa bits; E_WIDTH, 8, exponent bits; BIAS, 127, exponent bias.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Ports SHALL be as follows.
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operand pair valid.
- in_ready, output, 1, block can accept operands.
- floating1_in, input, D_WIDTH, IEEE-754 operand A.
- floating2_in, input, D_WIDTH, IEEE-754 operand B.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts the result.
- floating_multiplication_out, output, D_WIDTH, IEEE-754 product A*B.

Function
REQ-004 The FSM SHALL have four states: IDLE, MUL, NORM, DONE. in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-005 On in_valid && in_ready, the block SHALL register both operands. It SHALL latch sign = A[31]^B[31].
REQ-006 The block SHALL form 24-bit mantissas {1, frac} for each operand. A 10-bit signed exponent SHALL be computed as eA + eB - BIAS.
REQ-007 Special cases SHALL be detected in the accept cycle, and the FSM SHALL go directly to DONE with the following results.
- Either operand NaN (exp=255, frac!=0), or inf*zero: 0x7FC00000.
- Otherwise either operand inf: {sign, 8'hFF, 23'd0}.
- Otherwise either exponent 0 (zero or denormal flushed): {sign, 31'd0}.
REQ-008 Normal case: IDLE SHALL go to MUL. MUL SHALL run exactly 24 cycles of shift-add, one multiplier bit per cycle, LSB first, into a 48-bit accumulator. A 5-bit counter SHALL run 0..23, and the FSM SHALL go to NORM when the counter reaches 23.
REQ-009 NORM SHALL take one cycle and then go to DONE.
- If product[47]=1: mantissa = product[46:24], exponent +1.
- Else: mantissa = product[45:23].
- Truncate; no rounding.
REQ-010 After normalisation, the exponent SHALL be checked.
- Exponent >= 255: {sign, 8'hFF, 23'd0}.
- Exponent <= 0: {sign, 31'd0}.
- Otherwise: {sign, exp[7:0], mantissa}.
REQ-011 Latency from the accept edge to out_valid=1 SHALL be 26 cycles for the normal path and 1 cycle for special cases.
REQ-012 DONE SHALL hold out_valid and floating_multiplication_out stable until out_ready=1. On out_valid && out_ready, the FSM SHALL return to IDLE on that edge, and in_ready SHALL be 1 in the next cycle.
REQ-013 The block SHALL not pipeline: at most one operation is in flight. in_valid outside IDLE SHALL be ignored, and operands SHALL not be sampled.
REQ-014 floating_multiplication_out SHALL be registered. It SHALL hold the last result after handshake until the next result is written.
REQ-015 The shift-add accumulator SHALL be 48 bits wide with no carry loss; the maximum product (2^24-1)^2 < 2^48.

Reset
REQ-016 When rst_n=0, the block SHALL asynchronously force state=IDLE, counter=0, accumulator=0, out_valid=0, and floating_multiplication_out=0. in_ready SHALL be 1 while reset is deasserted in IDLE.
REQ-017 Reset asserted during MUL, NORM, or DONE SHALL abort the operation with no output. The first accept after release SHALL start a fresh operation.

Verification
REQ-018 The bench SHALL cover the following directed scenarios.
- 0x40400000 (3.0) * 0x40000000 (2.0) -> 0x40C00000, out_valid 26 cycles after accept.
- 0x3FC00000 * 0x3FC00000 (1.5*1.5) -> 0x40100000; exercises the product[47] normalise path.
- 0xC0000000 * 0x40400000 -> 0xC0C00000; 0x00000000 * 0x40400000 -> 0x00000000 with 1-cycle latency.
- 0x7F000000 * 0x7F000000 -> 0x7F800000 (overflow); 0x7F800000 * 0x00000000 -> 0x7FC00000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. Output SHALL stay stable and in_ready SHALL stay 0; in_valid pulses during this window SHALL be ignored.
- Reset: assert rst_n=0 at MUL cycle 12. Outputs SHALL go to 0 and the state to IDLE. The next 3.0*2.0 SHALL yield 0x40C00000 in 26 cycles.
